// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous double buffering
// Slot timing comes from a free-running prescaler; each slot opens with an anti-ghosting blank window.

module ssd_scan_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV_BITS = 18,
    parameter int GHOST_CYCLES  = 256
) (
    input  logic                      ClkPort,
    input  logic                      Reset,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_blank,
    output logic [NUM_DIGITS-1:0]     anodes,
    output logic [7:0]                cathodes,
    output logic                      frame_tick
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_BITS-1:0] GHOST    = SCAN_DIV_BITS'(GHOST_CYCLES);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // cnt restarts at 0, so the slot opens blanked unless the dead time is zero
    localparam state_t START_STATE = (GHOST_CYCLES > 0) ? BLANK : DRIVE;

    logic [SCAN_DIV_BITS-1:0] cnt;
    logic [SCAN_DIV_BITS-1:0] cnt_next;
    logic [IDX_W-1:0]         idx;
    logic                     slot_end;
    logic                     frame_end;

    logic [4*NUM_DIGITS-1:0]  pend_value;
    logic [NUM_DIGITS-1:0]    pend_dp;
    logic [NUM_DIGITS-1:0]    pend_en;
    logic                     pend_valid;
    logic [4*NUM_DIGITS-1:0]  disp_value;
    logic [NUM_DIGITS-1:0]    disp_dp;
    logic [NUM_DIGITS-1:0]    disp_en;

    state_t                   state;
    state_t                   state_next;
    logic [NUM_DIGITS-1:0]    lz_sup;
    logic                     zero_run;
    logic                     digit_off;
    logic [3:0]               nibble;
    logic [NUM_DIGITS-1:0]    anodes_d;
    logic [7:0]               cathodes_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0:    seg7 = 7'b0000001;
            4'h1:    seg7 = 7'b1001111;
            4'h2:    seg7 = 7'b0010010;
            4'h3:    seg7 = 7'b0000110;
            4'h4:    seg7 = 7'b1001100;
            4'h5:    seg7 = 7'b0100100;
            4'h6:    seg7 = 7'b0100000;
            4'h7:    seg7 = 7'b0001111;
            4'h8:    seg7 = 7'b0000000;
            4'h9:    seg7 = 7'b0000100;
            4'hA:    seg7 = 7'b0001000;
            4'hB:    seg7 = 7'b1100000;
            4'hC:    seg7 = 7'b0110001;
            4'hD:    seg7 = 7'b1000010;
            4'hE:    seg7 = 7'b0110000;
            default: seg7 = 7'b0111000;
        endcase
    endfunction

    assign cnt_next  = cnt + 1'b1;
    assign slot_end  = &cnt;
    assign frame_end = slot_end && (idx == LAST_IDX);

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= cnt_next;
            if (slot_end) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // A load on the boundary cycle bypasses pending so it is not delayed a whole frame
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_valid <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_en    <= '0;
        end else if (frame_end) begin
            pend_valid <= 1'b0;
            if (load) begin
                disp_value <= value_in;
                disp_dp    <= dp_in;
                disp_en    <= digit_en;
            end else if (pend_valid) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
                disp_en    <= pend_en;
            end
        end else if (load) begin
            pend_value <= value_in;
            pend_dp    <= dp_in;
            pend_en    <= digit_en;
            pend_valid <= 1'b1;
        end
    end

    always_comb begin
        zero_run = 1'b1;
        lz_sup   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_value[4*i +: 4] == 4'h0);
            if (i > 0) begin
                lz_sup[i] = zero_run & lz_blank;
            end
        end
    end

    assign nibble    = disp_value[{idx, 2'b00} +: 4];
    assign digit_off = !disp_en[idx] || lz_sup[idx];

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state <= START_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        anodes_d   = '1;
        cathodes_d = '1;
        case (state)
            BLANK:   if (cnt_next >= GHOST) state_next = DRIVE;
            DRIVE:   if (cnt_next < GHOST)  state_next = BLANK;
            default: state_next = BLANK;
        endcase
        if (state == DRIVE && !digit_off) begin
            anodes_d[idx] = 1'b0;
            cathodes_d    = {seg7(nibble), ~disp_dp[idx]};
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            anodes     <= '1;
            cathodes   <= '1;
            frame_tick <= 1'b0;
        end else begin
            anodes     <= anodes_d;
            cathodes   <= cathodes_d;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb/tb_ssd_scan_ctrl.sv - scoreboard bench for ssd_scan_ctrl with a 4-digit, 16-clock-slot configuration

module tb_ssd_scan_ctrl;

    logic        ClkPort = 1'b0;
    logic        Reset;
    logic        load;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        lz_blank;
    logic [3:0]  anodes;
    logic [7:0]  cathodes;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int k;
    logic pre_reset = 1'b1;

    typedef struct {
        int         k;
        logic [3:0] an;
        logic [7:0] cath;
        logic [7:0] mask;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    ssd_scan_ctrl #(
        .NUM_DIGITS   (4),
        .SCAN_DIV_BITS(4),
        .GHOST_CYCLES (2)
    ) dut (
        .ClkPort   (ClkPort),
        .Reset     (Reset),
        .load      (load),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .lz_blank  (lz_blank),
        .anodes    (anodes),
        .cathodes  (cathodes),
        .frame_tick(frame_tick)
    );

    always #5 ClkPort = ~ClkPort;

    // k = posedges since reset release; outputs seen after edge k reflect scan state k-1
    always @(posedge ClkPort or posedge Reset) begin
        if (Reset) k <= 0;
        else       k <= k + 1;
    end

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at k=%0d: got 0x%0h expected 0x%0h", name, k, act, exp_v);
        end
    endtask

    task automatic push(input int kk, input logic [3:0] an, input logic [7:0] cath,
                        input logic [7:0] mask, input string name);
        exp_t x;
        x.k = kk; x.an = an; x.cath = cath; x.mask = mask; x.name = name;
        sb.push_back(x);
    endtask

    always @(negedge ClkPort) begin
        if (!Reset && k > 0) begin
            while (sb.size() > 0 && sb[0].k <= k) begin
                e = sb.pop_front();
                if (e.k != k) begin
                    check({e.name, "_missed"}, k, e.k);
                end else begin
                    check({e.name, "_an"}, int'(anodes), int'(e.an));
                    if (e.mask != 8'h00)
                        check({e.name, "_cath"}, int'(cathodes & e.mask), int'(e.cath & e.mask));
                end
            end
            if (frame_tick || (k % 64 == 0))
                check("frame_tick", int'(frame_tick), int'(k % 64 == 0));
            if (((k - 1) % 16) < 2) begin
                check("ghost_an", int'(anodes), 'hF);
                check("ghost_cath", int'(cathodes), 'hFF);
            end
            if (pre_reset && k >= 385 && k <= 576)
                check("en0101_an13", int'({anodes[3], anodes[1]}), 3);
        end
    end

    task automatic wait_k(input int target);
        int guard = 0;
        @(negedge ClkPort);
        while (k != target && guard < 5000) begin
            @(negedge ClkPort);
            guard++;
        end
        if (k != target) check("wait_timeout", k, target);
    endtask

    task automatic do_load(input int p, input logic [15:0] v, input logic [3:0] dp,
                           input logic [3:0] en);
        wait_k(p - 1);
        load = 1'b1; value_in = v; dp_in = dp; digit_en = en;
        @(negedge ClkPort);
        load = 1'b0; value_in = 16'hFFFF; dp_in = 4'hF; digit_en = 4'hF;
    endtask

    initial begin
        Reset = 1'b1; load = 1'b0; value_in = '0; dp_in = '0; digit_en = '0; lz_blank = 1'b0;
        repeat (3) @(negedge ClkPort);
        check("rst_an", int'(anodes), 'hF);
        check("rst_cath", int'(cathodes), 'hFF);
        check("rst_tick", int'(frame_tick), 0);

        push(1,   4'hF, 8'hFF, 8'hFF, "first_blank");
        push(30,  4'hF, 8'h00, 8'h00, "dark_no_load");
        push(65,  4'hF, 8'hFF, 8'hFF, "f1_ghost0");
        push(66,  4'hF, 8'hFF, 8'hFF, "f1_ghost1");
        push(67,  4'hE, 8'h98, 8'hFF, "f1_s0_4dp");
        push(80,  4'hE, 8'h98, 8'hFF, "f1_s0_end");
        push(86,  4'hD, 8'h0D, 8'hFF, "f1_s1_3");
        push(102, 4'hB, 8'h25, 8'hFF, "f1_s2_2");
        push(115, 4'h7, 8'h9F, 8'hFF, "f1_s3_1");
        push(131, 4'hE, 8'h85, 8'hFF, "coinc_s0_d");
        push(160, 4'hD, 8'h63, 8'hFF, "hold_s1_C");
        push(180, 4'h7, 8'h11, 8'hFF, "coinc_s3_A");
        push(197, 4'hE, 8'h25, 8'hFF, "lastwin_s0");
        push(229, 4'hB, 8'h25, 8'hFF, "lastwin_s2");
        push(262, 4'hE, 8'h03, 8'hFF, "lz_s0_0");
        push(278, 4'hD, 8'h49, 8'hFF, "lz_s1_5");
        push(294, 4'hF, 8'h00, 8'h00, "lz_s2_dark");
        push(310, 4'hF, 8'h00, 8'h00, "lz_s3_dark");
        push(374, 4'h7, 8'h03, 8'hFF, "lzoff_s3_0");
        push(391, 4'hE, 8'h01, 8'hFF, "en_s0_8");
        push(407, 4'hF, 8'h00, 8'h00, "en_s1_dark");
        push(423, 4'hB, 8'h41, 8'hFF, "en_s2_6");

        @(negedge ClkPort);
        Reset = 1'b0;

        do_load(10,  16'h1234, 4'b0001, 4'b1111);
        do_load(128, 16'hABCD, 4'b0000, 4'b1111);
        do_load(140, 16'h1111, 4'b0000, 4'b1111);
        do_load(150, 16'h2222, 4'b0000, 4'b1111);
        do_load(200, 16'h0050, 4'b0000, 4'b1111);
        wait_k(230);
        lz_blank = 1'b1;
        wait_k(315);
        lz_blank = 1'b0;
        do_load(330, 16'h5678, 4'b0000, 4'b0101);
        do_load(600, 16'h9999, 4'b1111, 4'b1111);

        // slot 2, cnt 9 with digit 2 lit: reset must clear outputs without a clock edge
        wait_k(617);
        check("pre_rst_an", int'(anodes), 'hB);
        pre_reset = 1'b0;
        Reset = 1'b1;
        #1;
        check("async_rst_an", int'(anodes), 'hF);
        check("async_rst_cath", int'(cathodes), 'hFF);
        check("async_rst_tick", int'(frame_tick), 0);
        check("sb_drained_pre_rst", sb.size(), 0);
        @(negedge ClkPort);
        Reset = 1'b0;

        push(1,   4'hF, 8'hFF, 8'hFF, "post_rst_blank");
        push(67,  4'hF, 8'h00, 8'h00, "pend_discarded");
        push(131, 4'hE, 8'h71, 8'hFF, "post_rst_s0_F");
        push(180, 4'h7, 8'h03, 8'hFF, "post_rst_s3_0");

        do_load(100, 16'h000F, 4'b0000, 4'b1111);
        wait_k(200);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
